// File: rtl/game_board_ctrl.sv
// Game-flow controller for the board-grid overlay: IDLE/SETUP/PLAY/DONE sequencing,
// board size selection, frame-synchronised cursor with auto-repeat and cell-write strobe.
module game_board_ctrl #(
    parameter int MIN_SIZE      = 2,
    parameter int MAX_SIZE      = 4,
    parameter int DEFAULT_SIZE  = 3,
    parameter int REPEAT_FRAMES = 8,
    parameter int DONE_FRAMES   = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vblnk,
    input  logic       start_pulse,
    input  logic       confirm_pulse,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       game_over,
    output logic       is_game_on,
    output logic [2:0] board_size,
    output logic [3:0] cursor_x,
    output logic [3:0] cursor_y,
    output logic       cell_write,
    output logic [3:0] cell_x,
    output logic [3:0] cell_y,
    output logic [1:0] state
);

    // state | meaning
    // IDLE  | overlay off, waiting for start
    // SETUP | board size selection with left/right
    // PLAY  | cursor movement and cell placement
    // DONE  | end-of-game hold, timed return to IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        PLAY  = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam int RPT_W  = $clog2(REPEAT_FRAMES + 1);
    localparam int DONE_W = $clog2(DONE_FRAMES + 1);

    state_t            state_q, state_d;
    logic              is_game_on_q, is_game_on_d;
    logic [2:0]        size_q, size_d;
    logic [3:0]        cur_x_q, cur_x_d;
    logic [3:0]        cur_y_q, cur_y_d;
    logic              cell_write_q, cell_write_d;
    logic [3:0]        cell_x_q, cell_x_d;
    logic [3:0]        cell_y_q, cell_y_d;
    logic [RPT_W-1:0]  rpt_q, rpt_d;
    logic [DONE_W-1:0] done_q, done_d;
    logic              vblnk_q, vblnk_d;
    logic              tick_q, tick_d;
    dir_t              dir_q, dir_d;
    logic              dir_vld_q, dir_vld_d;

    logic              any_key;
    dir_t              cur_dir;
    logic              do_move;
    logic [4:0]        n_cells;
    logic [4:0]        last_cell;
    logic [RPT_W-1:0]  rpt_inc;
    logic [DONE_W-1:0] done_inc;

    assign n_cells   = {2'b00, size_q} * {2'b00, size_q};
    assign last_cell = n_cells - 5'd1;
    assign rpt_inc   = rpt_q + RPT_W'(1);
    assign done_inc  = done_q + DONE_W'(1);
    assign any_key   = key_up | key_down | key_left | key_right;

    always_comb begin
        cur_dir = DIR_RIGHT;
        if (key_up)        cur_dir = DIR_UP;
        else if (key_down) cur_dir = DIR_DOWN;
        else if (key_left) cur_dir = DIR_LEFT;
    end

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        cell_write_d = 1'b0;
        cell_x_d     = cell_x_q;
        cell_y_d     = cell_y_q;
        rpt_d        = rpt_q;
        done_d       = done_q;
        dir_d        = dir_q;
        dir_vld_d    = dir_vld_q;
        vblnk_d      = vblnk;
        tick_d       = vblnk & ~vblnk_q;
        do_move      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_pulse) state_d = SETUP;
            end
            SETUP: begin
                if (tick_q) begin
                    if (key_right && !key_left && (size_q < 3'(MAX_SIZE)))
                        size_d = size_q + 3'd1;
                    else if (key_left && !key_right && (size_q > 3'(MIN_SIZE)))
                        size_d = size_q - 3'd1;
                end
                if (confirm_pulse) begin
                    state_d   = PLAY;
                    cur_x_d   = 4'd0;
                    cur_y_d   = 4'd0;
                    rpt_d     = '0;
                    dir_vld_d = 1'b0;
                end
            end
            PLAY: begin
                if (confirm_pulse) begin
                    cell_write_d = 1'b1;
                    cell_x_d     = cur_x_q;
                    cell_y_d     = cur_y_q;
                end
                // Key state is only evaluated on frame ticks, so a tap must span a tick.
                if (tick_q && !game_over) begin
                    if (!any_key) begin
                        rpt_d     = '0;
                        dir_vld_d = 1'b0;
                    end else if (!dir_vld_q || (cur_dir != dir_q)) begin
                        do_move   = 1'b1;
                        rpt_d     = '0;
                        dir_d     = cur_dir;
                        dir_vld_d = 1'b1;
                    end else if (rpt_inc == RPT_W'(REPEAT_FRAMES)) begin
                        do_move = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_inc;
                    end
                end
                if (game_over) begin
                    state_d = DONE;
                    done_d  = '0;
                end
            end
            DONE: begin
                if (start_pulse) begin
                    state_d = SETUP;
                    done_d  = '0;
                end else if (tick_q) begin
                    if (done_inc == DONE_W'(DONE_FRAMES)) begin
                        state_d = IDLE;
                        done_d  = '0;
                    end else begin
                        done_d = done_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_move) begin
            case (cur_dir)
                DIR_UP:    cur_y_d = (cur_y_q == 4'd0) ? last_cell[3:0] : cur_y_q - 4'd1;
                DIR_DOWN:  cur_y_d = ({1'b0, cur_y_q} == last_cell) ? 4'd0 : cur_y_q + 4'd1;
                DIR_LEFT:  cur_x_d = (cur_x_q == 4'd0) ? last_cell[3:0] : cur_x_q - 4'd1;
                DIR_RIGHT: cur_x_d = ({1'b0, cur_x_q} == last_cell) ? 4'd0 : cur_x_q + 4'd1;
                default:   ;
            endcase
        end

        is_game_on_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            is_game_on_q <= 1'b0;
            size_q       <= 3'(DEFAULT_SIZE);
            cur_x_q      <= 4'd0;
            cur_y_q      <= 4'd0;
            cell_write_q <= 1'b0;
            cell_x_q     <= 4'd0;
            cell_y_q     <= 4'd0;
            rpt_q        <= '0;
            done_q       <= '0;
            vblnk_q      <= 1'b0;
            tick_q       <= 1'b0;
            dir_q        <= DIR_UP;
            dir_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_game_on_q <= is_game_on_d;
            size_q       <= size_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            cell_write_q <= cell_write_d;
            cell_x_q     <= cell_x_d;
            cell_y_q     <= cell_y_d;
            rpt_q        <= rpt_d;
            done_q       <= done_d;
            vblnk_q      <= vblnk_d;
            tick_q       <= tick_d;
            dir_q        <= dir_d;
            dir_vld_q    <= dir_vld_d;
        end
    end

    assign state      = state_q;
    assign is_game_on = is_game_on_q;
    assign board_size = size_q;
    assign cursor_x   = cur_x_q;
    assign cursor_y   = cur_y_q;
    assign cell_write = cell_write_q;
    assign cell_x     = cell_x_q;
    assign cell_y     = cell_y_q;

endmodule
